// File: rtl/mem_loader.sv
// mem_loader: assembles an incoming byte stream into WIDTH-bit words
// (little-endian) and writes len words to consecutive memory addresses
// starting at base, wrapping past DEPTH-1 back to 0.
// Optional feature: define MEM_LOADER_CHECKSUM_EN to enable the mod-256
// byte checksum on o_checksum; otherwise o_checksum is tied to 0.
module mem_loader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [$clog2(DEPTH)-1:0]   i_base_addr,
  input  logic [$clog2(DEPTH):0]     i_len,
  input  logic                       i_valid,
  input  logic [7:0]                 i_byte,
  output logic                       o_ready,
  output logic                       o_wr_en,
  output logic [$clog2(DEPTH)-1:0]   o_wr_addr,
  output logic [WIDTH-1:0]           o_din,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [7:0]                 o_checksum
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int BPW = WIDTH / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [AW-1:0]    addr_r;
  logic [LW-1:0]    len_r;
  logic [LW-1:0]    idx_r;
  logic [LW-1:0]    idx_inc_s;
  logic [BCW-1:0]   byte_cnt_r;
  logic [WIDTH-1:0] word_r;
  logic [WIDTH-1:0] word_nxt_s;
  logic             start_s;
  logic             accept_s;
  logic             last_byte_s;

  assign start_s     = (state_r == ST_IDLE) && i_start;
  assign accept_s    = (state_r == ST_LOAD) && i_valid;
  assign last_byte_s = (byte_cnt_r == LAST_BYTE);
  assign idx_inc_s   = idx_r + LW'(1);

  // Merge the byte currently offered into its little-endian lane of the word.
  always_comb begin
    word_nxt_s = word_r;
    for (int k = 0; k < BPW; k++) begin
      if (byte_cnt_r == BCW'(k)) begin
        word_nxt_s[8*k +: 8] = i_byte;
      end else begin
        word_nxt_s[8*k +: 8] = word_r[8*k +: 8];
      end
    end
  end

  // FSM state register; reset returns to IDLE from any state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != LW'(0)) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s && last_byte_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (idx_inc_s == len_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Transfer datapath: latch parameters, collect bytes, step address/index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_r     <= '0;
      len_r      <= '0;
      idx_r      <= '0;
      byte_cnt_r <= '0;
      word_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            addr_r     <= i_base_addr;
            len_r      <= i_len;
            idx_r      <= '0;
            byte_cnt_r <= '0;
            word_r     <= '0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            word_r <= word_nxt_s;
            if (last_byte_s) begin
              byte_cnt_r <= '0;
            end else begin
              byte_cnt_r <= byte_cnt_r + BCW'(1);
            end
          end
        end
        ST_WRITE: begin
          idx_r <= idx_inc_s;
          if (addr_r == LAST_ADDR) begin
            addr_r <= '0;
          end else begin
            addr_r <= addr_r + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs decoded from the state being entered, so each
  // output lines up with the state it describes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ready   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_din     <= '0;
    end else begin
      o_ready   <= (state_nxt_s == ST_LOAD);
      o_busy    <= (state_nxt_s != ST_IDLE);
      o_done    <= (state_nxt_s == ST_DONE);
      o_wr_en   <= (state_nxt_s == ST_WRITE);
      o_wr_addr <= (state_nxt_s == ST_WRITE) ? addr_r : '0;
      o_din     <= (state_nxt_s == ST_WRITE) ? word_nxt_s : '0;
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] checksum_r;

  // Running mod-256 sum of accepted bytes, restarted by each accepted start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      checksum_r <= 8'd0;
    end else if (start_s) begin
      checksum_r <= 8'd0;
    end else if (accept_s) begin
      checksum_r <= checksum_r + i_byte;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign o_checksum = checksum_r;
`else
  assign o_checksum = 8'd0;
`endif

endmodule
